// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline-stage skid register.
// The state enum is the single source of the handshake flags and
// occupancy; the helper functions decode those from a state value.
package pipe_pkg;

  // Occupancy of the stage: main only (BUSY) or main plus skid (FULL).
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  // Occupancy values reported on the count port.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Number of words held for a given state.
  function automatic logic [1:0] state_occupancy(input skid_state_t s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = OCC_EMPTY;
      BUSY:    occ = OCC_BUSY;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

  // Upstream may hand over a word unless both registers are occupied.
  function automatic logic state_accepts(input skid_state_t s);
    return (s == EMPTY) || (s == BUSY);
  endfunction

  // The main register holds a live word in any non-empty state.
  function automatic logic state_presents(input skid_state_t s);
    return (s == BUSY) || (s == FULL);
  endfunction

endpackage

// File: rtl/en_reg.sv
// Generalised write-enabled flip-flop: a WIDTH-bit register with a
// synchronous active-high reset to RESET_VALUE and a load enable.
// Reset wins over the enable so a reset edge always restores the
// known value regardless of what the control logic asks for.
module en_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled, otherwise hold; reset restores RESET_VALUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_pipe_reg.sv
// Pipeline register with a valid/ready handshake and a one-entry skid
// buffer. The main register always drives out_data; the skid register
// catches one extra word when downstream stalls while upstream still
// had in_ready high. The three-state FSM is the only source of the
// valid/ready flags and the occupancy count, so there is no
// combinational path from out_ready to in_ready.
//
// Optional feature: define SKID_PIPE_REG_FLUSH_EN to make flush squash
// both entries (state back to EMPTY, data registers untouched). Without
// the macro the flush port is present but has no effect.
module skid_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_t      state_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             flush_hit;
  logic             main_load;
  logic             skid_load;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

`ifdef SKID_PIPE_REG_FLUSH_EN
  assign flush_hit = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_hit    = 1'b0;
`endif

  // Flags come straight from the state register; only in_ready is also
  // gated by reset so upstream never sees a handover during reset.
  assign in_ready  = state_accepts(state_q) && !reset;
  assign out_valid = state_presents(state_q);
  assign count     = state_occupancy(state_q);
  assign out_data  = main_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Decode which data register loads this edge; a flush suppresses all
  // loads so the squashed words and any offered input are not stored.
  always_comb begin
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (!flush_hit) begin
      case (state_q)
        EMPTY: begin
          main_load = in_xfer;
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            skid_load = 1'b1;
          end
        end
        FULL: begin
          main_load      = out_xfer;
          main_from_skid = 1'b1;
        end
        default: begin
          main_load = 1'b0;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  en_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_main (
    .clk  (clk),
    .reset(reset),
    .en   (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  en_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .en   (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

  // Occupancy FSM: reset beats flush, flush beats the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else if (flush_hit) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && !out_xfer) begin
            state_q <= FULL;
          end else if (!in_xfer && out_xfer) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_q <= BUSY;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Self-checking bench for skid_pipe_reg. The driver pushes each word it
// expects to be accepted into a scoreboard queue; a separate monitor on
// the falling edge checks the handshake flags against a simple occupancy
// model and pops/compares out_data whenever an output transfer happens.
module tb_skid_pipe_reg;

  localparam int W = 32;
  localparam logic [W-1:0] RST_VAL = 32'h5A5A_0F0F;

`ifdef SKID_PIPE_REG_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] sb[$];
  int           occ        = 0;
  bit           prev_reset = 1'b0;
  bit           prev_hold  = 1'b0;
  logic [W-1:0] prev_data  = '0;

  bit           fl_act;
  bit           in_acc;
  bit           out_acc;
  logic [W-1:0] expd;

  skid_pipe_reg #(
    .WIDTH      (W),
    .RESET_VALUE(RST_VAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial forever #5 clk = ~clk;

  // Compare one observed value with its expectation and count it.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and record the
  // word in the scoreboard if the stage has room and nothing squashes it.
  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit r,
                               input bit rs, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    reset     = rs;
    flush     = fl;
    if (v && !rs && !(FLUSH_EN && fl) && occ < 2) sb.push_back(d);
  endtask

  // Monitor: check flags against the occupancy model, check ordering of
  // delivered words, reset value and stall stability, then advance model.
  always @(negedge clk) begin
    fl_act = FLUSH_EN && (flush === 1'b1);
    checkOutput("in_ready", 32'(in_ready), 32'(!reset && occ < 2));
    checkOutput("out_valid", 32'(out_valid), 32'(occ != 0));
    checkOutput("count", 32'(count), 32'(occ));
    if (prev_reset) checkOutput("reset_data", out_data, RST_VAL);
    if (prev_hold) checkOutput("stall_stable", out_data, prev_data);
    out_acc = (occ != 0) && out_ready && !reset && !fl_act;
    in_acc  = in_valid && !reset && !fl_act && (occ < 2);
    prev_hold  = (occ != 0) && !out_ready && !reset && !fl_act;
    prev_data  = out_data;
    prev_reset = reset;
    if (out_acc) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_underflow: got out_data %h expected no word at %0t", out_data, $time);
      end else begin
        expd = sb.pop_front();
        checkOutput("out_data", out_data, expd);
      end
    end
    if (reset || fl_act) begin
      occ = 0;
      sb.delete();
    end else begin
      occ = occ + int'(in_acc) - int'(out_acc);
    end
  end

  initial begin
    bit rs;
    bit fl;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_AAAA;
    out_ready = 1'b0;

    $display("[TB] reset with in_valid high");
    applyStimulus(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] streaming");
    applyStimulus(1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] stall and skid");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset while full");
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] flush while full");
    applyStimulus(1'b1, 32'h2A, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2B, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      rs = ($urandom_range(0, 499) == 0);
      fl = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 55, rs, fl);
    end

    repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
